// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the instruction sequencer:
//   state_t      - FSM state encoding (3-bit)
//   PH_*         - phase codes reported on the phase output
//   state_phase  - maps a state to its reported phase (0 outside FETCH..WB)
//   state_busy   - 1 for the in-flight states FETCH..WB
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  localparam logic [1:0] PH_FETCH  = 2'd0;
  localparam logic [1:0] PH_DECODE = 2'd1;
  localparam logic [1:0] PH_EXEC   = 2'd2;
  localparam logic [1:0] PH_WB     = 2'd3;

  function automatic logic [1:0] state_phase(input state_t s);
    case (s)
      ST_DECODE: return PH_DECODE;
      ST_EXEC:   return PH_EXEC;
      ST_WB:     return PH_WB;
      default:   return PH_FETCH;
    endcase
  endfunction

  function automatic logic state_busy(input state_t s);
    return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC) || (s == ST_WB);
  endfunction

endpackage

// File: rtl/cpu_tick_gen.sv
// Phase-tick prescaler.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   hold in  1 = keep the counter at 0 and suppress tick
//   tick out high in the clk where the counter sits at TICK_DIV-1
module cpu_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = w_last & ~hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_cnt <= '0;
    else if (hold || w_last) r_cnt <= '0;
    else                     r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH->DECODE->EXEC->WB at the
// prescaled tick rate, with free-run / single-step and latched HALT.
//   clk, rst                         clock, async active-high reset
//   run_mode, step_btn               raw controls (synchronised here)
//   dec_halt/write_en/alu_en/pc_ovr  decode info for current instruction
//   alu_en, rf_we, pc_en, pc_load    registered one-clk strobes
//   phase, busy, halted              registered status
//   instr_count                      retired instructions, saturating
import cpu_seq_pkg::*;

module cpu_sequencer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_mode,
  input  logic             step_btn,
  input  logic             dec_halt,
  input  logic             dec_write_en,
  input  logic             dec_alu_en,
  input  logic             dec_pc_ovr,
  output logic             alu_en,
  output logic             rf_we,
  output logic             pc_en,
  output logic             pc_load,
  output logic [1:0]       phase,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  logic   r_run_s1, r_run_s2;
  logic   r_step_s1, r_step_s2, r_step_d;
  logic   w_step_edge, w_tick, w_hold, w_wb_tick;
  state_t r_state, w_state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_s1  <= 1'b0;
      r_run_s2  <= 1'b0;
      r_step_s1 <= 1'b0;
      r_step_s2 <= 1'b0;
      r_step_d  <= 1'b0;
    end else begin
      r_run_s1  <= run_mode;
      r_run_s2  <= r_run_s1;
      r_step_s1 <= step_btn;
      r_step_s2 <= r_step_s1;
      r_step_d  <= r_step_s2;
    end
  end

  assign w_step_edge = r_step_s2 & ~r_step_d;
  assign w_hold      = (r_state == ST_HALTED);
  assign w_wb_tick   = (r_state == ST_WB) && w_tick;

  cpu_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .hold (w_hold),
    .tick (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // Free-run waits for a tick; single-step leaves IDLE on the edge itself.
      ST_IDLE:   if (r_run_s2 ? w_tick : w_step_edge) w_state_nxt = ST_FETCH;
      ST_FETCH:  if (w_tick) w_state_nxt = ST_DECODE;
      ST_DECODE: if (w_tick) w_state_nxt = dec_halt ? ST_HALTED : ST_EXEC;
      ST_EXEC:   if (w_tick) w_state_nxt = ST_WB;
      ST_WB:     if (w_tick) w_state_nxt = r_run_s2 ? ST_FETCH : ST_IDLE;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // with r_state without an extra cycle of lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      alu_en      <= 1'b0;
      rf_we       <= 1'b0;
      pc_en       <= 1'b0;
      pc_load     <= 1'b0;
      phase       <= PH_FETCH;
      busy        <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      alu_en  <= (r_state == ST_EXEC) && w_tick && dec_alu_en;
      rf_we   <= w_wb_tick && dec_write_en;
      pc_en   <= w_wb_tick;
      pc_load <= w_wb_tick && dec_pc_ovr;
      phase   <= state_phase(w_state_nxt);
      busy    <= state_busy(w_state_nxt);
      halted  <= (w_state_nxt == ST_HALTED);
      if (w_wb_tick && (instr_count != '1))
        instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, run_mode, step_btn, dec_halt, dec_write_en, dec_alu_en, dec_pc_ovr;

  logic a_alu, a_we, a_pe, a_pl, a_busy, a_halt;
  logic [1:0] a_ph;
  logic [15:0] a_cnt;
  logic b_alu, b_we, b_pe, b_pl, b_busy, b_halt;
  logic [1:0] b_ph;
  logic [15:0] b_cnt;
  logic c_alu, c_we, c_pe, c_pl, c_busy, c_halt;
  logic [1:0] c_ph;
  logic [3:0] c_cnt;

  cpu_sequencer #(.TICK_DIV(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step_btn(step_btn),
    .dec_halt(dec_halt), .dec_write_en(dec_write_en), .dec_alu_en(dec_alu_en),
    .dec_pc_ovr(dec_pc_ovr), .alu_en(a_alu), .rf_we(a_we), .pc_en(a_pe),
    .pc_load(a_pl), .phase(a_ph), .busy(a_busy), .halted(a_halt), .instr_count(a_cnt));

  cpu_sequencer #(.TICK_DIV(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step_btn(step_btn),
    .dec_halt(dec_halt), .dec_write_en(dec_write_en), .dec_alu_en(dec_alu_en),
    .dec_pc_ovr(dec_pc_ovr), .alu_en(b_alu), .rf_we(b_we), .pc_en(b_pe),
    .pc_load(b_pl), .phase(b_ph), .busy(b_busy), .halted(b_halt), .instr_count(b_cnt));

  cpu_sequencer #(.TICK_DIV(1), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step_btn(step_btn),
    .dec_halt(dec_halt), .dec_write_en(dec_write_en), .dec_alu_en(dec_alu_en),
    .dec_pc_ovr(dec_pc_ovr), .alu_en(c_alu), .rf_we(c_we), .pc_en(c_pe),
    .pc_load(c_pl), .phase(c_ph), .busy(c_busy), .halted(c_halt), .instr_count(c_cnt));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic al, we, pe, pl, input logic [1:0] ph,
                                     input logic bz, ht, input logic [15:0] cnt);
    return {40'd0, al, we, pe, pl, ph, bz, ht, cnt};
  endfunction

  // Reference model: instruction-level view (mode idle/busy/halted plus a
  // phase number), tick from a modulo counter, synchronisers as plain bits.
  typedef struct {
    bit r1, r2, s1, s2, sp;
    int tc;
    int mode;            // 0 idle, 1 busy, 2 halted
    int ph;
    bit alu, we, pe, pl;
    int unsigned cnt;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t m;
    m.r1 = 0; m.r2 = 0; m.s1 = 0; m.s2 = 0; m.sp = 0;
    m.tc = 0; m.mode = 0; m.ph = 0;
    m.alu = 0; m.we = 0; m.pe = 0; m.pl = 0; m.cnt = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit run, st, hl, wr, al, ov,
                                 input int td, input int unsigned cmax);
    mdl_t n = m;
    bit se = m.s2 && !m.sp;
    bit tk = (m.mode != 2) && (m.tc == td - 1);
    n.r1 = run; n.r2 = m.r1; n.s1 = st; n.s2 = m.s1; n.sp = m.s2;
    n.tc = (m.mode == 2 || tk) ? 0 : m.tc + 1;
    n.alu = 0; n.we = 0; n.pe = 0; n.pl = 0;
    if (m.mode == 0) begin
      if (m.r2 ? tk : se) begin n.mode = 1; n.ph = 0; end
    end else if (m.mode == 1 && tk) begin
      case (m.ph)
        0: n.ph = 1;
        1: if (hl) n.mode = 2; else n.ph = 2;
        2: begin n.ph = 3; n.alu = al; end
        default: begin
          n.pe = 1; n.pl = ov; n.we = wr;
          if (m.cnt < cmax) n.cnt = m.cnt + 1;
          n.ph = 0;
          n.mode = m.r2 ? 1 : 0;
        end
      endcase
    end
    return n;
  endfunction

  function automatic logic [63:0] mpk(input mdl_t m);
    return pk(m.alu, m.we, m.pe, m.pl, (m.mode == 1) ? 2'(m.ph) : 2'd0,
              m.mode == 1, m.mode == 2, 16'(m.cnt));
  endfunction

  typedef struct {
    bit run, st, hl, wr, al, ov;
    bit e_al, e_we, e_pe, e_pl;
    bit [1:0] e_ph;
    bit e_bz, e_ht;
    int unsigned e_cnt;
  } vec_t;

  function automatic vec_t mk(input bit run, st, hl, wr, al, ov, e_al, e_we, e_pe, e_pl,
                              input int e_ph, input bit e_bz, e_ht, input int unsigned e_cnt);
    vec_t v;
    v.run = run; v.st = st; v.hl = hl; v.wr = wr; v.al = al; v.ov = ov;
    v.e_al = e_al; v.e_we = e_we; v.e_pe = e_pe; v.e_pl = e_pl;
    v.e_ph = 2'(e_ph); v.e_bz = e_bz; v.e_ht = e_ht; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic setin(input bit run, st, hl, wr, al, ov);
    run_mode = run; step_btn = st; dec_halt = hl;
    dec_write_en = wr; dec_alu_en = al; dec_pc_ovr = ov;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[15];
    mdl_t ma, mb, mc;
    int first, npe, nstb, bad, flag;
    int pe_t[$];
    bit found, r;

    // Free-run, two instructions then HALT; halt outside DECODE is ignored.
    tbl[0]  = mk(1,0,0,1,1,0, 0,0,0,0, 0,0,0, 0);
    tbl[1]  = mk(1,0,0,1,1,0, 0,0,0,0, 0,0,0, 0);
    tbl[2]  = mk(1,0,0,1,1,0, 0,0,0,0, 0,1,0, 0);
    tbl[3]  = mk(1,0,1,1,1,0, 0,0,0,0, 1,1,0, 0);
    tbl[4]  = mk(1,0,0,1,1,0, 0,0,0,0, 2,1,0, 0);
    tbl[5]  = mk(1,0,1,1,1,0, 1,0,0,0, 3,1,0, 0);
    tbl[6]  = mk(1,0,0,1,1,0, 0,1,1,0, 0,1,0, 1);
    tbl[7]  = mk(1,0,0,1,1,0, 0,0,0,0, 1,1,0, 1);
    tbl[8]  = mk(1,0,0,1,1,0, 0,0,0,0, 2,1,0, 1);
    tbl[9]  = mk(1,0,0,1,0,0, 0,0,0,0, 3,1,0, 1);
    tbl[10] = mk(1,0,0,0,1,1, 0,0,1,1, 0,1,0, 2);
    tbl[11] = mk(1,0,0,1,1,0, 0,0,0,0, 1,1,0, 2);
    tbl[12] = mk(1,0,1,1,1,0, 0,0,0,0, 0,0,1, 2);
    tbl[13] = mk(1,1,0,1,1,0, 0,0,0,0, 0,0,1, 2);
    tbl[14] = mk(0,1,0,1,1,0, 0,0,0,0, 0,0,1, 2);

    rst = 1'b1;
    setin(1, 0, 0, 1, 1, 0);
    repeat (2) @(negedge clk);
    chk("reset_state", pk(a_alu,a_we,a_pe,a_pl,a_ph,a_busy,a_halt,a_cnt), 64'd0);

    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      setin(tbl[i].run, tbl[i].st, tbl[i].hl, tbl[i].wr, tbl[i].al, tbl[i].ov);
      @(negedge clk);
      chk($sformatf("table_row%0d", i),
          pk(a_alu,a_we,a_pe,a_pl,a_ph,a_busy,a_halt,a_cnt),
          pk(tbl[i].e_al,tbl[i].e_we,tbl[i].e_pe,tbl[i].e_pl,tbl[i].e_ph,
             tbl[i].e_bz,tbl[i].e_ht,16'(tbl[i].e_cnt)));
    end

    // Reset mid-EXEC and in the pc_en clk: asynchronous clear.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    setin(1, 0, 0, 1, 1, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (a_ph == 2'd2 && a_busy) found = 1;
    end
    chk("reach_exec", found, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_exec", pk(a_alu,a_we,a_pe,a_pl,a_ph,a_busy,a_halt,a_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (a_pe) found = 1;
    end
    chk("reach_pc_en", found, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_pc_en", pk(a_alu,a_we,a_pe,a_pl,a_ph,a_busy,a_halt,a_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_mode = 1'b0;
    flag = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_busy || a_pe || a_alu || a_we) flag++;
    end
    chk("idle_after_rst", flag, 0);

    // Single step; a second pulse while busy is dropped.
    first = -1; npe = 0;
    for (int i = 0; i < 20; i++) begin
      step_btn = (i < 2) || (i == 3) || (i == 4);
      @(negedge clk);
      if (a_pe) begin
        npe++;
        if (first < 0) first = i + 1;
      end
    end
    chk("step_pe_count", npe, 1);
    chk("step_latency", (first >= 1 && first <= 7), 1);
    chk("step_back_idle", {a_busy, a_ph, a_halt}, 0);
    chk("step_count", a_cnt, 1);

    // HALT decoded: latched, no strobes, steps ignored, reset clears.
    dec_halt = 1'b1;
    nstb = 0;
    for (int i = 0; i < 10; i++) begin
      step_btn = (i < 2);
      @(negedge clk);
      if (a_alu || a_we || a_pe) nstb++;
    end
    chk("halt_entered", {a_halt, a_busy, a_ph}, 4'b1000);
    dec_halt = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step_btn = (i % 4) < 2;
      @(negedge clk);
      if (a_alu || a_we || a_pe) nstb++;
    end
    chk("halt_no_strobes", nstb, 0);
    chk("halt_held", {a_halt, a_busy, a_cnt}, {1'b1, 1'b0, 16'd1});
    rst = 1'b1;
    #1;
    chk("halt_rst_clear", a_halt, 0);
    @(negedge clk);

    // Free-run jumps: pc_load only with pc_en; TICK_DIV=3 spacing; saturation.
    rst = 1'b0;
    setin(1, 0, 0, 1, 1, 1);
    bad = 0;
    for (int t = 1; t <= 120; t++) begin
      @(negedge clk);
      if (b_pe !== b_pl || a_pe !== a_pl) bad++;
      if (b_pe) pe_t.push_back(t);
    end
    chk("jump_pl_qualify", bad, 0);
    chk("jump_pe_seen", pe_t.size() >= 3, 1);
    for (int k = 1; k < pe_t.size(); k++)
      chk($sformatf("jump_spacing%0d", k), pe_t[k] - pe_t[k-1], 12);
    chk("freerun_count", a_cnt, 29);
    chk("sat_count", c_cnt, 15);

    // Randomised run against the reference models.
    rst = 1'b1;
    setin(0, 0, 0, 0, 0, 0);
    ma = mreset(); mb = mreset(); mc = mreset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      chk("rnd_td1", pk(a_alu,a_we,a_pe,a_pl,a_ph,a_busy,a_halt,a_cnt), mpk(ma));
      chk("rnd_td3", pk(b_alu,b_we,b_pe,b_pl,b_ph,b_busy,b_halt,b_cnt), mpk(mb));
      chk("rnd_cnt4", pk(c_alu,c_we,c_pe,c_pl,c_ph,c_busy,c_halt,{12'd0,c_cnt}), mpk(mc));
      r = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 63) == 0) run_mode = ~run_mode;
      if ($urandom_range(0, 2) == 0) step_btn = ~step_btn;
      dec_halt     = ($urandom_range(0, 29) == 0);
      dec_write_en = 1'($urandom_range(0, 1));
      dec_alu_en   = 1'($urandom_range(0, 1));
      dec_pc_ovr   = 1'($urandom_range(0, 1));
      rst = r;
      if (r) begin
        ma = mreset(); mb = mreset(); mc = mreset();
      end else begin
        ma = mstep(ma, run_mode, step_btn, dec_halt, dec_write_en, dec_alu_en, dec_pc_ovr, 1, 65535);
        mb = mstep(mb, run_mode, step_btn, dec_halt, dec_write_en, dec_alu_en, dec_pc_ovr, 3, 65535);
        mc = mstep(mc, run_mode, step_btn, dec_halt, dec_write_en, dec_alu_en, dec_pc_ovr, 1, 15);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
